// File: rtl/pc_gen_if.sv
// Fetch-side bundle for pc_gen: the redirect sources and fetch handshake in, and the
// request PC with its slot qualifiers out.
interface pc_gen_if #(
    parameter int FETCH_WIDTH = 2
);
    logic                   fetch_ready;
    logic                   is_eret;
    logic [31:0]            epc;
    logic                   is_INTEXC;
    logic [31:0]            entrance;
    logic                   branch_taken;
    logic [31:0]            pc_branch;
    logic                   select_refetchD;
    logic [31:0]            refetchD_pc;
    logic                   decode_taken;
    logic [31:0]            pre_pc;
    logic                   zero_prej;
    logic                   pred_taken;
    logic [31:0]            pc_o;
    logic                   pc_valid_o;
    logic [FETCH_WIDTH-1:0] slot_mask_o;
    logic                   misalign_o;
    logic                   redirect_o;

    modport master (
        output fetch_ready, is_eret, epc, is_INTEXC, entrance, branch_taken, pc_branch,
               select_refetchD, refetchD_pc, decode_taken, pre_pc, zero_prej, pred_taken,
        input  pc_o, pc_valid_o, slot_mask_o, misalign_o, redirect_o
    );

    modport slave (
        input  fetch_ready, is_eret, epc, is_INTEXC, entrance, branch_taken, pc_branch,
               select_refetchD, refetchD_pc, decode_taken, pre_pc, zero_prej, pred_taken,
        output pc_o, pc_valid_o, slot_mask_o, misalign_o, redirect_o
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch-stage next-PC generator: prioritised redirects, bundle stepping, and a one-entry
// buffer that holds the strongest back-end redirect seen while fetch is stalled.
module pc_gen #(
    parameter int          FETCH_WIDTH = 2,
    parameter logic [31:0] RESET_PC    = 32'hbfc00000
) (
    input logic    clk,
    input logic    resetn,
    pc_gen_if.slave bus
);
    localparam int BSZ = FETCH_WIDTH * 4;

    typedef enum logic [2:0] {
        LVL_SEQ     = 3'd0,
        LVL_PRED    = 3'd1,
        LVL_ZERO    = 3'd2,
        LVL_DECODE  = 3'd3,
        LVL_REFETCH = 3'd4,
        LVL_BRANCH  = 3'd5,
        LVL_INTEXC  = 3'd6,
        LVL_ERET    = 3'd7
    } level_e;

    logic [31:0] pc_q;
    logic        valid_q;
    logic        redirect_q;
    logic        pend_valid;
    level_e      pend_lvl;
    logic [31:0] pend_tgt;

    logic [31:0] seq_pc;
    level_e      live_lvl;
    logic [31:0] live_tgt;
    level_e      fire_lvl;
    logic [31:0] fire_tgt;
    logic        fire;
    logic        latch_pend;
    logic [31:0] word_off;
    logic        misalign;

    assign seq_pc = (pc_q & ~32'(BSZ - 1)) + 32'(BSZ);
    assign fire   = valid_q & bus.fetch_ready;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        live_lvl = LVL_SEQ;
        live_tgt = seq_pc;
        if (bus.is_eret) begin
            live_lvl = LVL_ERET;    live_tgt = bus.epc;
        end else if (bus.is_INTEXC) begin
            live_lvl = LVL_INTEXC;  live_tgt = bus.entrance;
        end else if (bus.branch_taken) begin
            live_lvl = LVL_BRANCH;  live_tgt = bus.pc_branch;
        end else if (bus.select_refetchD) begin
            live_lvl = LVL_REFETCH; live_tgt = bus.refetchD_pc;
        end else if (bus.decode_taken) begin
            live_lvl = LVL_DECODE;  live_tgt = bus.pre_pc;
        end else if (bus.zero_prej) begin
            live_lvl = LVL_ZERO;    live_tgt = pc_q;
        end else if (bus.pred_taken) begin
            live_lvl = LVL_PRED;    live_tgt = bus.pre_pc;
        end
    end

    // Live beats pending on a tie; pending only wins when strictly stronger.
    always_comb begin
        fire_lvl = live_lvl;
        fire_tgt = live_tgt;
        if (pend_valid && (pend_lvl > live_lvl)) begin
            fire_lvl = pend_lvl;
            fire_tgt = pend_tgt;
        end
    end

    // Only back-end sources are buffered; the newest wins a tie with what is held.
    assign latch_pend = (live_lvl >= LVL_REFETCH) && (!pend_valid || (live_lvl >= pend_lvl));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            redirect_q <= 1'b0;
            pend_valid <= 1'b0;
            pend_lvl   <= LVL_SEQ;
            pend_tgt   <= '0;
        end else begin
            valid_q <= 1'b1;
            if (fire) begin
                pc_q       <= fire_tgt;
                redirect_q <= (fire_lvl >= LVL_ZERO);
                pend_valid <= 1'b0;
            end else begin
                redirect_q <= 1'b0;
                if (latch_pend) begin
                    pend_valid <= 1'b1;
                    pend_lvl   <= live_lvl;
                    pend_tgt   <= live_tgt;
                end
            end
        end
    end

    assign misalign = (pc_q[1:0] != 2'b00);
    assign word_off = (pc_q >> 2) & 32'(FETCH_WIDTH - 1);

    always_comb begin
        bus.slot_mask_o = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (!misalign && (32'(i) >= word_off)) bus.slot_mask_o[i] = 1'b1;
        end
    end

    assign bus.pc_o       = pc_q;
    assign bus.pc_valid_o = valid_q;
    assign bus.misalign_o = misalign;
    assign bus.redirect_o = redirect_q;
endmodule
